// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one repeated-addition multiplier among N
// requesters, with a WAIT-state timeout and fully registered handshake outputs.
module mult_arbiter #(
   parameter int N   = 4,
   parameter int W   = 16,
   parameter int TMO = 70000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] a_in,
   input  logic [N*W-1:0] b_in,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   rsp_valid,
   output logic [2*W-1:0] rsp_data,
   output logic           rsp_err,
   output logic           busy,
   output logic           mul_start,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic           mul_done,
   input  logic [2*W-1:0] mul_p
);
   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TMO + 1);
   localparam logic [2:0] IDLE = 3'd0, GRANT = 3'd1, START = 3'd2, WAIT = 3'd3, RESP = 3'd4;
   logic [2:0]     state_q, state_d;
   logic [LW-1:0]  win_q, win_d, last_q, last_d, pick, idx;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           mul_done_q, done_ev;
   logic [N-1:0]   gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
   logic [2*W-1:0] rsp_data_q, rsp_data_d;
   logic           rsp_err_q, rsp_err_d, busy_q, busy_d, mul_start_q, mul_start_d;
   logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;

   // Scan from last+N down to last+1 so the nearest requester after last wins.
   always_comb begin
      pick = last_q;
      idx  = '0;
      for (int k = N; k >= 1; k--) begin
         idx = LW'((int'(last_q) + k) % N);
         if (req[idx]) pick = idx;
      end
   end

   assign done_ev = mul_done & ~mul_done_q;

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      case (state_q)
         IDLE: if (|req) begin
            state_d = GRANT;
            win_d   = pick;
         end
         GRANT: begin
            mul_a_d = a_in[int'(win_q)*W +: W];
            mul_b_d = b_in[int'(win_q)*W +: W];
            state_d = START;
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: if (done_ev) begin
            rsp_data_d = mul_p;
            rsp_err_d  = 1'b0;
            state_d    = RESP;
         end else if (cnt_q == CW'(TMO - 1)) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         RESP: begin
            last_d  = win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      gnt_d       = (state_d == GRANT) ? N'(1) << win_d : '0;
      rsp_valid_d = (state_d == RESP) ? N'(1) << win_d : '0;
      mul_start_d = state_d == START;
      busy_d      = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         win_q       <= '0;
         last_q      <= LW'(N - 1);
         cnt_q       <= '0;
         mul_done_q  <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mul_done_q  <= mul_done;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign mul_start = mul_start_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one repeated-addition multiplier datapath (operand registers A/B, product register P, down-counting B) among N requesters. A round-robin winner is picked, its operands are latched and the multiplier is started. The block waits for the multiplier's done with a timeout, then returns the product to the winner. It sits between client blocks and the single multiplier instance in the design.

## Interface
- N, 4, number of requesters (2..8)
- W, 16, operand width; product is 2W
- TMO, 70000, max WAIT cycles before abort; must exceed 2^W + 4
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  per-requester request level
- a_in  in  N*W  operand A, requester i in bits [i*W +: W]
- b_in  in  N*W  operand B, same packing
- gnt  out  N  one-hot, one-cycle pulse: operands of that requester captured
- rsp_valid  out  N  one-hot, one-cycle pulse: rsp_data/rsp_err valid for that requester
- rsp_data  out  2W  product; 0 on timeout
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout
- busy  out  1  high in every state except IDLE
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a, mul_b  out  W each  latched operands, stable from GRANT+1 until next GRANT
- mul_done  in  1  multiplier done level
- mul_p  in  2W  multiplier product

## Operation
- States: IDLE, GRANT, START, WAIT, RESP.
- IDLE: if req != 0, winner = first set bit searching from (last+1) mod N upward with wrap; store winner; go GRANT. req is sampled only in IDLE.
- GRANT: gnt[winner]=1; mul_a/mul_b <= winner's a_in/b_in; go START.
- START: mul_start=1; timeout counter <= 0; go WAIT.
- WAIT: done event = mul_done & ~mul_done_q, where mul_done_q is mul_done registered every cycle. On a done event: rsp_data <= mul_p, rsp_err <= 0, go RESP. Else, if counter == TMO-1: rsp_data <= 0, rsp_err <= 1, go RESP. Else counter++.
- RESP: rsp_valid[winner]=1; last <= winner; go IDLE.
- Requester protocol: hold req and operands until gnt. Drop req the cycle after gnt. A req still high when the FSM re-enters IDLE is a new request. Dropping req before gnt is legal and leaves no side effect.
- Multiplier contract: deasserts mul_done within 2 cycles of mul_start. A stale high done from the previous operation never produces an event, because only a rising edge inside WAIT counts.
- Reset values: state IDLE, last = N-1 (requester 0 first), gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, mul_start=0, mul_a=0, mul_b=0, counter=0, mul_done_q=0.
- Reset mid-operation: immediate return to the reset values. No rsp_valid is issued for the aborted operation. The multiplier shares rst_n and is reset with it.
- Simultaneous requests: exactly one gnt per arbitration; the others wait in IDLE order.
- Done event and timeout in the same cycle: done wins (rsp_err=0).
- Operand B=0 is legal; the arbiter treats it like any other operand.

## Timing
- req seen at edge 0 in IDLE: gnt high in cycle 1, mul_start high in cycle 2, WAIT from cycle 3.
- Done rising edge sampled at edge k (k≥3): rsp_valid high in cycle k+1. Minimum req→rsp_valid latency is 4 cycles.
- Timeout: rsp_valid with rsp_err=1 arrives exactly TMO+1 cycles after mul_start.
- Back-to-back: next gnt no earlier than 2 cycles after rsp_valid (RESP→IDLE→GRANT).
- All outputs are registered; no combinational path from req or mul_done to any output.

## Test plan
- Single request: req=0001, a=7, b=5, multiplier done 5 cycles after start -> gnt=0001 at cycle 1, mul_start at 2, rsp_valid=0001 with rsp_data=35 and rsp_err=0.
- Round-robin from reset: req=1111 held, each requester drops req after its own gnt -> grant order 0,1,2,3. A second burst of req=1111 after last=3 starts again at 0.
- Fairness across rounds: req=0101 continuously re-raised -> grants alternate 0,2,0,2. Requester 0 never wins twice in a row.
- Timeout with TMO=16 and mul_done stuck low -> rsp_valid 17 cycles after mul_start, rsp_err=1, rsp_data=0, busy drops the cycle after.
- Stale done: mul_done held high from the previous op through START and falling 2 cycles later, then rising -> exactly one response, carrying the new product.
- rst_n pulsed low during WAIT -> all outputs 0 asynchronously, no rsp_valid. After release, req=0010 -> gnt=0010 at cycle 1.
